digit_frame_builder: RTL and testbench

- Sequential, parametrised BCD-to-bitmap frame generator for the clock display path.
- Accepts an `NUM_DIGITS`-digit BCD value over a valid/ready handshake and renders it into a committed frame buffer, one digit per cycle, using the team's 4x8 digit font.
- Streams the finished frame row by row to the display driver over a second valid/ready interface.
- Adds two things the fixed 4-digit combinational frame path lacks: optional leading-zero blanking, and optional per-digit blinking.

---
 rtl/digit_frame_pkg.sv | 32 +++
 rtl/digit_frame_builder_glyph_rom.sv | 22 ++
 rtl/digit_frame_builder.sv | 207 ++++++++++++++++++++
 tb/tb_digit_frame_builder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_frame_pkg.sv
// Shared constants, FSM state type and 4x8 digit font for the digit frame path.
package digit_frame_pkg;

    localparam int unsigned GLYPH_W     = 4;
    localparam int unsigned GLYPH_ROWS  = 8;
    localparam int unsigned GLYPH_BITS  = GLYPH_W * GLYPH_ROWS;
    localparam int unsigned NUM_GLYPHS  = 10;
    localparam int unsigned ROW_IDX_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUILD  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // Element 7 is row 0 so the packed glyph reads top row first in hex.
    typedef logic [GLYPH_ROWS-1:0][GLYPH_W-1:0] glyph_t;

    localparam glyph_t FONT [NUM_GLYPHS] = '{
        32'h0EAAAE00,   // 0
        32'h026A2200,   // 1
        32'h0E2E8E00,   // 2
        32'h0E262E00,   // 3
        32'h0AAE2200,   // 4
        32'h0E8E2E00,   // 5
        32'h0E8EAE00,   // 6
        32'h0E264400,   // 7
        32'h0EAEAE00,   // 8
        32'h0EAE2E00    // 9
    };

endpackage

// File: rtl/digit_frame_builder_glyph_rom.sv
// Combinational font lookup; non-decimal codes and blanked digits render empty.
module glyph_rom
    import digit_frame_pkg::*;
(
    input  logic [GLYPH_W-1:0]    digit,
    input  logic                  blank,
    output logic [GLYPH_BITS-1:0] glyph
);

    // Font table lookup with a blank override
    always_comb begin
        glyph = '0;
        if (!blank) begin
            for (int i = 0; i < int'(NUM_GLYPHS); i++) begin
                if (digit == GLYPH_W'(i)) begin
                    glyph = FONT[i];
                end
            end
        end
    end

endmodule

// File: rtl/digit_frame_builder.sv
// BCD-to-bitmap frame builder: renders one digit per cycle into a shadow
// buffer, commits the whole frame at once, then streams it row by row.
// Optional per-digit blinking is compiled in with DIGIT_BLINK_EN.
module digit_frame_builder
    import digit_frame_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned LEAD_ZERO_BLANK = 0
`ifdef DIGIT_BLINK_EN
    ,
    parameter int unsigned BLINK_HALF      = 25_000_000
`endif
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [GLYPH_W*NUM_DIGITS-1:0]             in_bcd,
`ifdef DIGIT_BLINK_EN
    input  logic [NUM_DIGITS-1:0]                     blink_mask,
`endif
    output logic [GLYPH_ROWS*GLYPH_W*NUM_DIGITS-1:0]  frame_data,
    output logic                                      frame_valid,
    output logic                                      row_valid,
    input  logic                                      row_ready,
    output logic [GLYPH_W*NUM_DIGITS-1:0]             row_data,
    output logic [ROW_IDX_W-1:0]                      row_idx,
    output logic                                      row_last
);

    localparam int unsigned RW = GLYPH_W * NUM_DIGITS;
    localparam int unsigned KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                          state_q;
    state_t                          state_d;
    logic                            accept;
    logic                            commit;
    logic                            row_hs;

    logic [RW-1:0]                   bcd_q;
    logic [KW-1:0]                   k_q;
    logic                            lead_q;
    logic [GLYPH_ROWS-1:0][RW-1:0]   shadow_q;
    logic [GLYPH_ROWS-1:0][RW-1:0]   shadow_d;
    logic [GLYPH_ROWS-1:0][RW-1:0]   frame_q;

    logic [GLYPH_W-1:0]              cur_digit;
    logic                            last_digit;
    logic                            blink_blank;
    logic                            blank;
    glyph_t                          glyph;
    logic [ROW_IDX_W-1:0]            row_next;

    assign cur_digit  = bcd_q[RW-1 -: GLYPH_W];
    assign last_digit = (k_q == KW'(NUM_DIGITS - 1));
    assign row_next   = row_idx + ROW_IDX_W'(1);
    assign frame_data = frame_q;

`ifdef DIGIT_BLINK_EN
    localparam int unsigned BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BCW-1:0]        blink_cnt;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] mask_q;
    logic                  blink_off_q;

    // Free-running blink phase; phase 0 is "on"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BCW'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BCW'(1);
        end
    end

    // Mask and phase are frozen for the whole frame at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q      <= '0;
            blink_off_q <= 1'b0;
        end else if (accept) begin
            mask_q      <= blink_mask;
            blink_off_q <= blink_phase;
        end else if (state_q == S_BUILD) begin
            mask_q      <= mask_q << 1;
        end
    end

    assign blink_blank = blink_off_q && mask_q[NUM_DIGITS-1];
`else
    assign blink_blank = 1'b0;
`endif

    // Leading zeros blank only while every earlier digit was also zero
    assign blank = blink_blank ||
                   ((LEAD_ZERO_BLANK != 0) && lead_q && (cur_digit == '0) && !last_digit);

    glyph_rom u_glyph_rom (
        .digit (cur_digit),
        .blank (blank),
        .glyph (glyph)
    );

    // Shift the current glyph into the low nibble of every row; digit 0 ends up on top
    always_comb begin
        shadow_d = shadow_q;
        for (int r = 0; r < int'(GLYPH_ROWS); r++) begin
            shadow_d[r] = (shadow_q[r] << GLYPH_W) | RW'(glyph[r]);
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        row_hs  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = S_BUILD;
                end
            end
            S_BUILD: begin
                if (last_digit) begin
                    commit  = 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (row_valid && row_ready) begin
                    row_hs = 1'b1;
                    if (row_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and input handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d == S_IDLE);
        end
    end

    // Capture and per-digit rendering into the shadow buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q    <= '0;
            k_q      <= '0;
            lead_q   <= 1'b0;
            shadow_q <= '0;
        end else if (accept) begin
            bcd_q    <= in_bcd;
            k_q      <= '0;
            lead_q   <= 1'b1;
            shadow_q <= '0;
        end else if (state_q == S_BUILD) begin
            bcd_q    <= bcd_q << GLYPH_W;
            k_q      <= k_q + KW'(1);
            lead_q   <= lead_q && (cur_digit == '0);
            shadow_q <= shadow_d;
        end
    end

    // Atomic frame commit and row streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q     <= '0;
            frame_valid <= 1'b0;
            row_valid   <= 1'b0;
            row_data    <= '0;
            row_idx     <= '0;
            row_last    <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                frame_q   <= shadow_d;
                row_valid <= 1'b1;
                row_idx   <= '0;
                row_data  <= shadow_d[GLYPH_ROWS-1];
                row_last  <= 1'b0;
            end else if (row_hs) begin
                if (row_last) begin
                    row_valid <= 1'b0;
                end else begin
                    row_idx   <= row_next;
                    row_data  <= frame_q[~row_next];
                    row_last  <= (row_next == ROW_IDX_W'(GLYPH_ROWS - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_frame_builder.sv
// Directed bench: default instance and a leading-zero-blanking instance,
// fed the same stimulus. Blink checks are built only with DIGIT_BLINK_EN.
module tb_digit_frame_builder;

    localparam int unsigned ND = 4;
    localparam int unsigned RW = 4 * ND;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [RW-1:0]   in_bcd = '0;
    logic            row_ready = 1'b1;
    logic [ND-1:0]   blink_mask = '0;

    logic            in_ready_a, frame_valid_a, row_valid_a, row_last_a;
    logic [8*RW-1:0] frame_data_a;
    logic [RW-1:0]   row_data_a;
    logic [2:0]      row_idx_a;
    logic            in_ready_b, frame_valid_b, row_valid_b, row_last_b;
    logic [8*RW-1:0] frame_data_b;
    logic [RW-1:0]   row_data_b;
    logic [2:0]      row_idx_b;

    int checks = 0;
    int failures = 0;

    logic [15:0] rows_a [8];
    logic [15:0] rows_b [8];
    logic [15:0] exp_1234 [8];

    always #5 clk = ~clk;

    digit_frame_builder #(
        .NUM_DIGITS(ND), .LEAD_ZERO_BLANK(0)
`ifdef DIGIT_BLINK_EN
        , .BLINK_HALF(4)
`endif
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_bcd(in_bcd),
`ifdef DIGIT_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .frame_data(frame_data_a), .frame_valid(frame_valid_a), .row_valid(row_valid_a),
        .row_ready(row_ready), .row_data(row_data_a), .row_idx(row_idx_a), .row_last(row_last_a)
    );

    digit_frame_builder #(
        .NUM_DIGITS(ND), .LEAD_ZERO_BLANK(1)
`ifdef DIGIT_BLINK_EN
        , .BLINK_HALF(4)
`endif
    ) u_lzb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_bcd(in_bcd),
`ifdef DIGIT_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .frame_data(frame_data_b), .frame_valid(frame_valid_b), .row_valid(row_valid_b),
        .row_ready(row_ready), .row_data(row_data_b), .row_idx(row_idx_b), .row_last(row_last_b)
    );

    // Reference blink phase: toggles every 4 cycles out of reset
    int bcnt;
    bit bph;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= 0;
            bph  <= 1'b0;
        end else if (bcnt == 3) begin
            bcnt <= 0;
            bph  <= ~bph;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for in_ready (and optionally a blink phase), then present one value for one edge
    task automatic send(input logic [15:0] bcd, input int want_phase);
        int  n;
        bit  ok;
        n = 0;
        @(negedge clk);
        forever begin
            ok = in_ready_a;
`ifdef DIGIT_BLINK_EN
            if (want_phase >= 0 && bph != want_phase[0]) ok = 1'b0;
`endif
            if (ok || n >= 200) break;
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(ok), 64'd1);
        in_bcd   = bcd;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Accept one value with row_ready high and capture all 8 rows of both instances
    task automatic run_frame(input logic [15:0] bcd, input int want_phase);
        int lat;
        int bad;
        row_ready = 1'b1;
        send(bcd, want_phase);
        lat = 1;
        while (!frame_valid_a && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("fv_latency", 64'(lat), 64'(ND + 1));
        bad = 0;
        for (int r = 0; r < 8; r++) begin
            rows_a[r] = row_data_a;
            rows_b[r] = row_data_b;
            if (!row_valid_a || row_idx_a != 3'(r)) bad++;
            if (row_last_a != (r == 7)) bad++;
            if (r == 1 && frame_valid_a) bad++;
            if (in_ready_a) bad++;
            @(negedge clk);
        end
        check("row_sequence", 64'(bad), 64'd0);
        check("ready_after_last", 64'({in_ready_a, row_valid_a}), 64'b10);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int fv_seen;
        exp_1234 = '{16'h0000, 16'h2EEA, 16'h622A, 16'hAE6E,
                     16'h2822, 16'h2EE2, 16'h0000, 16'h0000};

        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",   64'(in_ready_a), 64'd1);
        check("rst_outputs",    64'({frame_valid_a, row_valid_a, row_last_a, row_idx_a}), 64'd0);
        check("rst_row_data",   64'(row_data_a), 64'd0);
        check("rst_frame_data", 64'(|frame_data_a), 64'd0);
        rst = 1'b0;

        // Basic frame 1234
        run_frame(16'h1234, -1);
        for (int r = 0; r < 8; r++) check($sformatf("f1234_row%0d", r), 64'(rows_a[r]), 64'(exp_1234[r]));
        check("f1234_frame_row3", 64'(frame_data_a[(8-3)*RW-1 -: RW]), 64'hAE6E);
        check("f1234_lzb_row1", 64'(rows_b[1]), 64'h2EEA);

        // Leading-zero blanking
        run_frame(16'h0007, -1);
        check("lz0007_row1", 64'(rows_b[1]), 64'h000E);
        check("lz0007_row4", 64'(rows_b[4]), 64'h0004);
        check("nolz0007_row1", 64'(rows_a[1]), 64'hEEEE);
        run_frame(16'h0000, -1);
        check("lz0000_row1", 64'(rows_b[1]), 64'h000E);
        check("nolz0000_row1", 64'(rows_a[1]), 64'hEEEE);
        run_frame(16'h0102, -1);
        check("lz0102_row1", 64'(rows_b[1]), 64'h02EE);
        check("nolz0102_row1", 64'(rows_a[1]), 64'hE2EE);

        // Invalid BCD code renders empty
        run_frame(16'h12F4, -1);
        check("inval_row1", 64'(rows_a[1]), 64'h2E0A);
        check("inval_row5", 64'(rows_a[5]), 64'h2E02);

        // Stall on row 2 with an ignored second request
        row_ready = 1'b0;
        send(16'h1234, -1);
        n = 0;
        while (!frame_valid_a && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("stall_frame_seen", 64'(frame_valid_a), 64'd1);
        row_ready = 1'b1;
        repeat (2) @(negedge clk);
        row_ready = 1'b0;
        in_bcd    = 16'h9999;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_row_data", 64'(row_data_a), 64'h622A);
            check("stall_ctl", 64'({row_valid_a, row_idx_a, row_last_a, in_ready_a}), 64'b1_010_0_0);
            @(negedge clk);
            in_valid = 1'b0;
        end
        row_ready = 1'b1;
        n = 0;
        fv_seen = 0;
        while (!in_ready_a && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (ND + 3) begin
            if (frame_valid_a) fv_seen++;
            @(negedge clk);
        end
        check("stall_no_second_frame", 64'(fv_seen), 64'd0);
        check("stall_frame_kept", 64'(frame_data_a[(8-1)*RW-1 -: RW]), 64'h2EEA);
        check("stall_idle", 64'({in_ready_a, row_valid_a}), 64'b10);

        // Reset in the middle of streaming
        row_ready = 1'b1;
        send(16'h1234, -1);
        n = 0;
        while (!(row_valid_a && row_idx_a == 3'd4) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("mid_row4_reached", 64'(row_idx_a), 64'd4);
        rst = 1'b1;
        #1;
        check("mid_rst_async", 64'({in_ready_a, frame_valid_a, row_valid_a, row_last_a, row_idx_a}),
              64'b1_0_0_0_000);
        check("mid_rst_data", 64'({|frame_data_a, |row_data_a}), 64'd0);
        @(negedge clk);
        check("mid_rst_hold", 64'({in_ready_b, row_valid_b, |row_data_a}), 64'b100);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release", 64'({in_ready_a, row_valid_a}), 64'b10);

`ifdef DIGIT_BLINK_EN
        // Blink: last digit masked; blank only when accepted in the off phase
        blink_mask = 4'b0001;
        run_frame(16'h1234, 1);
        check("blink_off_row1", 64'(rows_a[1]), 64'h2EE0);
        run_frame(16'h1234, 0);
        check("blink_on_row1", 64'(rows_a[1]), 64'h2EEA);
        blink_mask = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
